// File: rtl/mnist_nn_pkg.sv
// ---------------------------------------------------------------------------
// mnist_nn_pkg
// Shared constants and types for the MNIST fully connected inference chain.
//   Q15_DATA_W  : word width of all activations (signed Q15)
//   L1_IN/OUT   : first layer input and output counts
//   fc_state_e  : inter-layer restreamer state encoding
// ---------------------------------------------------------------------------
package mnist_nn_pkg;

   localparam int unsigned Q15_DATA_W = 16;

   localparam int unsigned L1_IN  = 784;
   localparam int unsigned L1_OUT = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      STREAM  = 2'd2,
      TAIL    = 2'd3
   } fc_state_e;

endpackage

// File: rtl/q15_relu.sv
// ---------------------------------------------------------------------------
// q15_relu
// Combinational ReLU clamp for signed Q15 words.
// Build option: FC_RESTREAM_RELU_EN
//   defined   : negative inputs are clamped to zero
//   undefined : bit-exact passthrough
// Ports:
//   x : input word (signed, DATA_W bits)
//   y : clamped / passed-through word
// ---------------------------------------------------------------------------
module q15_relu #(
   parameter int unsigned DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);

`ifdef FC_RESTREAM_RELU_EN
   assign y = x[DATA_W-1] ? '0 : x;
`else
   assign y = x;
`endif

endmodule

// File: rtl/fc_relu_restreamer.sv
// ---------------------------------------------------------------------------
// fc_relu_restreamer
// Captures one FC layer's output words plus its end-of-frame pulse, applies
// the optional ReLU at capture, buffers the whole frame and re-transmits it as
// the next layer's input stream (N_OUT valid words, then one start-only tail).
// Build option: FC_RESTREAM_RELU_EN enables the ReLU clamp (see q15_relu).
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   in_data      : upstream neuron word (signed Q15)
//   in_valid     : in_data valid
//   in_done      : one-cycle end-of-frame pulse from upstream
//   out_start    : start strobe to downstream, N_OUT+1 cycles per frame
//   out_data     : streamed word, zero whenever out_valid is low
//   out_valid    : out_data valid
//   busy         : state is not IDLE
//   overflow     : sticky, a word arrived with no room to store it
//   short_frame  : sticky, frame ended with fewer than N_OUT words
// ---------------------------------------------------------------------------
module fc_relu_restreamer
   import mnist_nn_pkg::*;
#(
   parameter int unsigned N_OUT  = L1_OUT,
   parameter int unsigned DATA_W = Q15_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_done,
   output logic              out_start,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              busy,
   output logic              overflow,
   output logic              short_frame
);

   localparam int unsigned CNT_W = $clog2(N_OUT + 1);
   localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [CNT_W-1:0] N_OUT_C = CNT_W'(N_OUT);

   fc_state_e         state_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [CNT_W-1:0]  rd_cnt_q;
   logic [DATA_W-1:0] buf_q [N_OUT];
   logic              out_start_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              overflow_q;
   logic              short_frame_q;

   logic [DATA_W-1:0] relu_data;
   logic              wr_en;
   logic [CNT_W-1:0]  wr_cnt_d;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] first_word;
   logic [DATA_W-1:0] stream_word;

   q15_relu #(
      .DATA_W (DATA_W)
   ) u_relu (
      .x (in_data),
      .y (relu_data)
   );

   assign wr_idx = wr_cnt_q[IDX_W-1:0];
   assign rd_idx = rd_cnt_q[IDX_W-1:0];

   // wr_cnt_q is zero in IDLE, so the same write path serves the first word
   always_comb begin
      wr_en    = in_valid && ((state_q == IDLE) ||
                              ((state_q == COLLECT) && (wr_cnt_q != N_OUT_C)));
      wr_cnt_d = wr_en ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
   end

   // Word 0 leaves on the in_done edge, so it may still be in flight this cycle
   always_comb begin
      if (wr_cnt_d == '0) begin
         first_word = '0;
      end else if (wr_cnt_q == '0) begin
         first_word = relu_data;
      end else begin
         first_word = buf_q[0];
      end
      stream_word = (rd_cnt_q < wr_cnt_q) ? buf_q[rd_idx] : '0;
   end

   // Buffer contents are don't-care after reset, so no reset here
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_idx] <= relu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         out_start_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         overflow_q    <= 1'b0;
         short_frame_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, COLLECT: begin
               if (in_valid && !wr_en) begin
                  overflow_q <= 1'b1;
               end
               wr_cnt_q <= wr_cnt_d;
               if (in_done) begin
                  if (wr_cnt_d != N_OUT_C) begin
                     short_frame_q <= 1'b1;
                  end
                  state_q     <= STREAM;
                  out_start_q <= 1'b1;
                  out_valid_q <= 1'b1;
                  out_data_q  <= first_word;
                  rd_cnt_q    <= CNT_W'(1);
               end else if (wr_en) begin
                  state_q <= COLLECT;
               end
            end
            STREAM: begin
               // Single buffer, not re-armed: any new word is lost
               if (in_valid) begin
                  overflow_q <= 1'b1;
               end
               if (rd_cnt_q != N_OUT_C) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= stream_word;
                  rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
               end else begin
                  // Start stays high one extra cycle for downstream completion
                  state_q     <= TAIL;
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
               end
            end
            TAIL: begin
               if (in_valid) begin
                  overflow_q <= 1'b1;
               end
               state_q     <= IDLE;
               out_start_q <= 1'b0;
               wr_cnt_q    <= '0;
               rd_cnt_q    <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_start   = out_start_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = (state_q != IDLE);
   assign overflow    = overflow_q;
   assign short_frame = short_frame_q;

endmodule

// File: tb/tb_fc_relu_restreamer.sv
// ---------------------------------------------------------------------------
// tb_fc_relu_restreamer
// Directed self-checking bench for fc_relu_restreamer (N_OUT=32, DATA_W=16).
// Expected stream values follow the FC_RESTREAM_RELU_EN build option.
// ---------------------------------------------------------------------------
module tb_fc_relu_restreamer;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_done;
   logic        out_start;
   logic [15:0] out_data;
   logic        out_valid;
   logic        busy;
   logic        overflow;
   logic        short_frame;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [N];

   fc_relu_restreamer #(
      .N_OUT  (N),
      .DATA_W (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_done     (in_done),
      .out_start   (out_start),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .overflow    (overflow),
      .short_frame (short_frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] relu_f(input logic [15:0] x);
`ifdef FC_RESTREAM_RELU_EN
      return x[15] ? 16'h0000 : x;
`else
      return x;
`endif
   endfunction

   // Inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < N; i++) exp_q[i] = 16'h0000;
   endtask

   task automatic send_word(input logic [15:0] w, input logic done);
      in_valid = 1'b1;
      in_data  = w;
      in_done  = done;
      step();
      in_valid = 1'b0;
      in_data  = 16'h0000;
      in_done  = 1'b0;
   endtask

   task automatic send_done();
      in_done = 1'b1;
      step();
      in_done = 1'b0;
   endtask

   // Called right after the in_done edge; checks N words, the tail and idle.
   // inj >= 0 drives a stray in_valid during that stream word.
   task automatic check_stream(input string tag, input int inj);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_word%0d", tag, i), {15'd0, out_start, out_valid, out_data},
               {15'd0, 1'b1, 1'b1, exp_q[i]});
         if (i == inj) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
         end
         step();
         in_valid = 1'b0;
         in_data  = 16'h0000;
      end
      check({tag, "_tail"}, {out_start, out_valid, out_data, busy}, {1'b1, 1'b0, 16'h0000, 1'b1});
      step();
      check({tag, "_idle"}, {out_start, out_valid, out_data, busy}, {1'b0, 1'b0, 16'h0000, 1'b0});
   endtask

   initial begin
      reset    = 1'b1;
      in_data  = 16'h0000;
      in_valid = 1'b0;
      in_done  = 1'b0;
      do_reset();

      // Reset state
      check("reset_outs", {out_start, out_valid, out_data, busy, overflow, short_frame},
            {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});

      // Normal frame 0x0001..0x0020, done one cycle after the last word
      for (int i = 0; i < N; i++) begin
         exp_q[i] = 16'(i + 1);
         send_word(16'(i + 1), 1'b0);
         if (i == 0) check("busy_collect", {31'd0, busy}, 32'd1);
      end
      send_done();
      check_stream("normal", -1);
      check("normal_flags", {30'd0, overflow, short_frame}, 32'd0);

      // Alternating 0x8000 / 0x7FFF
      for (int i = 0; i < N; i++) begin
         logic [15:0] w;
         w = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
         exp_q[i] = relu_f(w);
         send_word(w, 1'b0);
      end
      send_done();
      check_stream("relu", -1);

      // Last word and done in the same cycle
      for (int i = 0; i < N; i++) begin
         exp_q[i] = 16'h0A00 + 16'(i);
         send_word(16'h0A00 + 16'(i), (i == N - 1));
      end
      check_stream("same_cycle", -1);
      check("same_cycle_flags", {30'd0, overflow, short_frame}, 32'd0);

      // Short frame of 20 words
      clear_exp();
      for (int i = 0; i < 20; i++) begin
         exp_q[i] = 16'h0100 + 16'(i);
         send_word(16'h0100 + 16'(i), 1'b0);
      end
      send_done();
      check("short_flag", {30'd0, overflow, short_frame}, 32'd1);
      check_stream("short", -1);
      do_reset();
      check("short_cleared", {30'd0, overflow, short_frame}, 32'd0);

      // Overflow: 33 words, the last must be dropped
      for (int i = 0; i < N; i++) begin
         exp_q[i] = 16'h2000 + 16'(i);
         send_word(16'h2000 + 16'(i), 1'b0);
      end
      check("ovf_before", {31'd0, overflow}, 32'd0);
      send_word(16'h5555, 1'b0);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      send_done();
      check("ovf_short", {31'd0, short_frame}, 32'd0);
      check_stream("ovf", -1);
      do_reset();

      // Done with no data from IDLE: all zero stream; stray word sets overflow
      clear_exp();
      send_done();
      check("empty_flags", {30'd0, overflow, short_frame}, 32'd1);
      check_stream("empty", 5);
      check("stream_in_valid_ovf", {31'd0, overflow}, 32'd1);
      do_reset();

      // Reset at stream word 10, then a fresh frame
      for (int i = 0; i < N; i++) begin
         exp_q[i] = 16'h0300 + 16'(i);
         send_word(16'h0300 + 16'(i), 1'b0);
      end
      send_word(16'h7777, 1'b0);
      send_done();
      for (int i = 0; i < 10; i++) begin
         check($sformatf("pre_rst_word%0d", i), {16'd0, out_data}, {16'd0, exp_q[i]});
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_outs", {out_start, out_valid, out_data, busy, overflow, short_frame},
            {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < N; i++) begin
         exp_q[i] = 16'h7F00 - 16'(i);
         send_word(16'h7F00 - 16'(i), 1'b0);
      end
      send_done();
      check_stream("fresh", -1);
      check("fresh_flags", {30'd0, overflow, short_frame}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fc_relu_restreamer.md
Name: fc_relu_restreamer

Overview:
- Receiving end of a fully connected layer's output stream: captures one `out_data`/`out_valid` word per neuron and the end-of-layer `done` pulse.
- Applies optional ReLU, buffers the full layer result, then re-transmits it as the next layer's input stream (`start` + `in_data`/`in_valid`).
- Sits between FC layer N and FC layer N+1 in the MNIST inference chain.

Parameters:
- N_OUT, 32, number of neuron outputs per frame; equals downstream layer input count.
- DATA_W, 16, word width; signed Q15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  neuron output word from upstream layer (signed Q15).
- in_valid  input  1  in_data valid this cycle.
- in_done  input  1  one-cycle pulse: upstream layer finished the frame.
- out_start  output  1  start strobe to downstream layer.
- out_data  output  DATA_W  streamed word to downstream layer.
- out_valid  output  1  out_data valid this cycle.
- busy  output  1  high in any state other than IDLE.
- overflow  output  1  sticky: a word arrived with buffer already full.
- short_frame  output  1  sticky: in_done arrived with fewer than N_OUT words.

Behaviour:
- Reset values: out_start=0, out_data=0, out_valid=0, busy=0, overflow=0, short_frame=0; state=IDLE; wr_cnt=0; rd_cnt=0.
- Reset applies on any cycle, including mid-COLLECT or mid-STREAM; buffer contents are not cleared and are don't-care.
- Buffer: N_OUT x DATA_W registers. wr_cnt and rd_cnt are clog2(N_OUT+1) bits wide.
- IDLE:
  - First in_valid writes buf[0] and moves to COLLECT with wr_cnt=1.
  - An in_done pulse with no prior data in IDLE sets short_frame and moves to STREAM; all N_OUT words streamed are zero.
- COLLECT:
  - Each in_valid with wr_cnt<N_OUT writes buf[wr_cnt]=f(in_data) and increments wr_cnt.
  - in_valid with wr_cnt==N_OUT drops the word and sets overflow.
  - in_done moves to STREAM. If in_valid and in_done are high in the same cycle, the word is written first, then the transition occurs.
  - If wr_cnt<N_OUT after that write, set short_frame; unwritten slots stream as 0.
- STREAM:
  - Starts the cycle after in_done (latency 1).
  - For N_OUT consecutive cycles: out_start=1, out_valid=1, out_data=buf[rd_cnt], or 0 when rd_cnt >= the captured count. rd_cnt increments each cycle.
  - No gaps, no backpressure.
- TAIL:
  - One cycle with out_start=1, out_valid=0, out_data=0, so the downstream counter-complete check sees start.
  - Then IDLE, with wr_cnt and rd_cnt cleared.
  - Total out_start high time = N_OUT+1 cycles.
- Inputs during STREAM/TAIL: in_valid and in_done are ignored. Any in_valid received also sets overflow, because the buffer is single and not re-armed.
- Sticky flags clear only on reset.
- Arithmetic:
  - f(x) = 0 if x[DATA_W-1]==1 and RELU_EN is defined; otherwise f(x) = x.
  - No rescaling; Q15 is preserved.
- out_data: registered, and driven 0 whenever out_valid=0.

Optional Feature:
- Macro: FC_RESTREAM_RELU_EN.
- Defined: negative words are clamped to 0 at capture, so the ReLU sits between layers.
- Undefined: words are stored and streamed bit-exact (linear passthrough), for bypass and debug of raw layer outputs.

Decomposition:
- Shared package `mnist_nn_pkg`:
  - Q15 width constant (DATA_W=16).
  - Per-layer size constants (L1_IN=784, L1_OUT=32).
  - State enum typedef {IDLE, COLLECT, STREAM, TAIL}.
- One natural sub-module: `q15_relu` (combinational clamp, macro-gated), reusable by later layers.
- Buffer and FSM stay in this module.

Test Plan:
- Normal frame, N_OUT=32, RELU on:
  - Stimulus: feed 0x0001..0x0020, then in_done one cycle after the last word.
  - Required: out_valid high 32 consecutive cycles starting 1 cycle after in_done, data 0x0001..0x0020; out_start high 33 cycles; busy low afterwards.
- ReLU clamp:
  - Stimulus: words alternating 0x8000, 0x7FFF.
  - RELU on: stream 0x0000, 0x7FFF, ...
  - RELU off: stream 0x8000, 0x7FFF, ...
- Same-cycle last word and done:
  - Stimulus: word 32 with in_valid and in_done together.
  - Required: word captured; stream has 32 words; short_frame=0.
- Short frame:
  - Stimulus: 20 words, then in_done.
  - Required: short_frame=1; stream words 0..19 as sent, words 20..31 = 0x0000.
- Overflow:
  - Stimulus: 33 words before in_done.
  - Required: overflow=1; 33rd word dropped; stream equals first 32 words.
- Reset mid-STREAM:
  - Stimulus: assert reset at stream word 10.
  - Required: next cycle all outputs 0, busy=0, flags cleared; a fresh frame then streams correctly.
